// File: rtl/rdy_vld_elastic_buf.sv
// Elastic buffer for rdy/vld links: circular storage of DEPTH beats with
// strict in-order replay, optional empty-and-ready cut-through, occupancy
// reporting and a synchronous flush. in_rdy is a flop and never looks at out_rdy.
module rdy_vld_elastic_buf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2,
  parameter bit          BYPASS = 1'b0,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_vld,
  output logic              in_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              flush_q;

  logic              empty;
  logic              bypass_hit;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  count_next;

  // Pointer advance with explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake decode and next occupancy.
  always_comb begin
    empty      = (count == '0);
    bypass_hit = BYPASS & empty & in_vld & out_rdy & ~flush_q;
    out_vld    = ~empty | bypass_hit;
    push       = in_vld & in_rdy & ~bypass_hit;
    pop        = out_vld & out_rdy & ~empty;
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Head of storage, or the live input while cutting through.
  always_comb begin
    out_data = mem[rd_ptr];
    if (bypass_hit) begin
      out_data = in_data;
    end
  end

  // Occupancy, pointers, flush pipeline and registered in_rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      flush_q <= 1'b0;
      in_rdy  <= 1'b1;
    end else if (flush) begin
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      flush_q <= 1'b1;
      in_rdy  <= 1'b0;
    end else begin
      count   <= count_next;
      flush_q <= 1'b0;
      in_rdy  <= (count_next < FULL_CNT);
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  // Payload storage; data needs no reset since pointers gate its visibility.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

`ifndef SYNTHESIS
  a_count_range : assert property (@(posedge clk) disable iff (rst) count <= FULL_CNT);
  a_no_overfill : assert property (@(posedge clk) disable iff (rst) !(push && count == FULL_CNT));
  a_no_underrun : assert property (@(posedge clk) disable iff (rst) !(pop && empty));
  a_hold_output : assert property (@(posedge clk) disable iff (rst)
                                   (!empty && !out_rdy && !flush) |=> $stable(out_data));
`endif

endmodule

// File: tb/tb_rdy_vld_elastic_buf.sv
// Bench for rdy_vld_elastic_buf: three configurations share one stimulus
// stream, each checked every cycle against a queue-style occupancy model.
module tb_rdy_vld_elastic_buf;

  localparam int NI = 3;
  localparam int DW = 16;
  localparam int unsigned DEP [NI] = '{4, 2, 3};
  localparam bit          BYP [NI] = '{1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          flush;
  logic          in_vld;
  logic          out_rdy;
  logic [DW-1:0] in_data;
  logic          rdy  [NI];
  logic          ovld [NI];
  logic [DW-1:0] od   [NI];
  logic [2:0]    cnt0;
  logic [1:0]    cnt1;
  logic [1:0]    cnt2;
  int unsigned   cnt  [NI];

  assign cnt[0] = 32'(cnt0);
  assign cnt[1] = 32'(cnt1);
  assign cnt[2] = 32'(cnt2);

  rdy_vld_elastic_buf #(.DATA_W(DW), .DEPTH(4), .BYPASS(1'b0)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_vld(in_vld), .in_rdy(rdy[0]),
    .out_data(od[0]), .out_vld(ovld[0]), .out_rdy(out_rdy), .count(cnt0));
  rdy_vld_elastic_buf #(.DATA_W(DW), .DEPTH(2), .BYPASS(1'b0)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_vld(in_vld), .in_rdy(rdy[1]),
    .out_data(od[1]), .out_vld(ovld[1]), .out_rdy(out_rdy), .count(cnt1));
  rdy_vld_elastic_buf #(.DATA_W(DW), .DEPTH(3), .BYPASS(1'b1)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_vld(in_vld), .in_rdy(rdy[2]),
    .out_data(od[2]), .out_vld(ovld[2]), .out_rdy(out_rdy), .count(cnt2));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: per instance a list of stored beats (head/tail counters) and a flush-shadow bit.
  logic [DW-1:0] mq [NI][256];
  int unsigned   hd [NI];
  int unsigned   tl [NI];
  bit            fq [NI];
  bit            mv = 1'b0;

  function automatic int unsigned msz(input int i);
    return tl[i] - hd[i];
  endfunction
  function automatic bit m_rdy(input int i);
    return (msz(i) < DEP[i]) && !fq[i];
  endfunction
  function automatic bit m_bh(input int i);
    return BYP[i] && (msz(i) == 0) && in_vld && out_rdy && !fq[i];
  endfunction
  function automatic logic [DW-1:0] m_head(input int i);
    return mq[i][8'(hd[i])];
  endfunction

  // Model update at each rising edge.
  initial begin
    for (int i = 0; i < NI; i++) begin
      hd[i] = 0; tl[i] = 0; fq[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
        bit r, b;
        if (rst) begin
          hd[i] = 0; tl[i] = 0; fq[i] = 1'b0;
        end else if (flush) begin
          hd[i] = tl[i]; fq[i] = 1'b1;
        end else begin
          r = m_rdy(i);
          b = m_bh(i);
          if (msz(i) != 0 && out_rdy) hd[i]++;
          if (in_vld && r && !b) begin
            mq[i][8'(tl[i])] = in_data;
            tl[i]++;
          end
          fq[i] = 1'b0;
        end
      end
      if (rst) mv = 1'b1;
    end
  end

  // Per-cycle comparison of every instance against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (mv) begin
        for (int i = 0; i < NI; i++) begin
          bit eb;
          bit ev;
          eb = m_bh(i);
          ev = (msz(i) != 0) || eb;
          chk($sformatf("u%0d.in_rdy", i), 32'(rdy[i]), 32'(m_rdy(i)));
          chk($sformatf("u%0d.out_vld", i), 32'(ovld[i]), 32'(ev));
          chk($sformatf("u%0d.count", i), cnt[i], msz(i));
          if (ev) chk($sformatf("u%0d.out_data", i), 32'(od[i]), 32'(eb ? in_data : m_head(i)));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit r);
    in_vld  = v;
    in_data = d;
    out_rdy = r;
  endtask

  task automatic drain();
    flush = 1'b0;
    drive(1'b0, '0, 1'b1);
    repeat (6) cyc();
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] v4 [4];
  int unsigned   seq_in;
  int unsigned   sb_next;
  int unsigned   delivered;
  int unsigned   cycles;
  bit            acc;
  bit            hold;

  initial begin
    v4 = '{16'h11, 16'h22, 16'h33, 16'h44};
    rst = 1'b1; flush = 1'b0;
    drive(1'b1, 16'hEE, 1'b0);
    cyc(); cyc();

    // Reset release: nothing stored, input side open.
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst.u%0d.in_rdy", i), 32'(rdy[i]), 32'd1);
      chk($sformatf("rst.u%0d.out_vld", i), 32'(ovld[i]), 32'd0);
      chk($sformatf("rst.u%0d.count", i), cnt[i], 32'd0);
    end
    chk("rst.model_size", msz(0), 32'd0);
    cyc();

    // Fill DEPTH=4 with downstream stalled, then drain.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, v4[k], 1'b0);
      cyc();
    end
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("fill.count", cnt[0], 32'd4);
    chk("fill.in_rdy", 32'(rdy[0]), 32'd0);
    chk("fill.model_size", msz(0), 32'd4);
    cyc();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, 1'b1);
      @(negedge clk);
      chk("drain.data", 32'(od[0]), 32'(v4[k]));
      chk("drain.vld", 32'(ovld[0]), 32'd1);
      chk("drain.count", cnt[0], 32'(4 - k));
      cyc();
    end
    @(negedge clk);
    chk("drain.empty_count", cnt[0], 32'd0);
    chk("drain.empty_vld", 32'(ovld[0]), 32'd0);
    drain();

    // Streaming through DEPTH=2: one beat per cycle, one cycle of latency.
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 16'(16'h0100 + k), 1'b1);
      if (k >= 1) begin
        @(negedge clk);
        chk("stream.data", 32'(od[1]), 32'(16'h0100 + k - 1));
        chk("stream.count", cnt[1], 32'd1);
        chk("stream.in_rdy", 32'(rdy[1]), 32'd1);
      end
      cyc();
    end
    drain();

    // Random stalls on DEPTH=2 with an in-order scoreboard of 1000 beats.
    seq_in = 0; sb_next = 0; delivered = 0; cycles = 0; hold = 1'b0;
    while (delivered < 1000 && cycles < 20000) begin
      if (!hold) in_vld = ($urandom_range(0, 3) != 0);
      in_data = 16'(seq_in);
      out_rdy = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = in_vld && rdy[1];
      if (ovld[1] && out_rdy) begin
        chk("sb.order", 32'(od[1]), 32'(16'(sb_next)));
        sb_next++;
        delivered++;
      end
      hold = in_vld && !acc;
      cyc();
      cycles++;
      if (acc) seq_in++;
    end
    if (delivered < 1000) chk("sb.timeout", delivered, 32'd1000);
    drain();

    // Cut-through when empty and ready; stored when downstream stalls.
    drive(1'b1, 16'hAB, 1'b1);
    @(negedge clk);
    chk("byp.vld", 32'(ovld[2]), 32'd1);
    chk("byp.data", 32'(od[2]), 32'h00AB);
    chk("byp.count", cnt[2], 32'd0);
    chk("byp.reg_vld", 32'(ovld[0]), 32'd0);
    cyc();
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    chk("byp.after_count", cnt[2], 32'd0);
    chk("byp.after_vld", 32'(ovld[2]), 32'd0);
    cyc();
    drive(1'b1, 16'hAB, 1'b0);
    @(negedge clk);
    chk("byp.stall_vld", 32'(ovld[2]), 32'd0);
    cyc();
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("byp.stored_count", cnt[2], 32'd1);
    chk("byp.stored_vld", 32'(ovld[2]), 32'd1);
    chk("byp.stored_data", 32'(od[2]), 32'h00AB);
    cyc();
    drain();

    // Full plus pop on DEPTH=3: pop only, in_rdy rises a cycle later.
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 16'(k), 1'b0);
      cyc();
    end
    drive(1'b1, 16'd4, 1'b1);
    @(negedge clk);
    chk("full.count", cnt[2], 32'd3);
    chk("full.in_rdy", 32'(rdy[2]), 32'd0);
    chk("full.head", 32'(od[2]), 32'd1);
    cyc();
    @(negedge clk);
    chk("full.pop_count", cnt[2], 32'd2);
    chk("full.pop_in_rdy", 32'(rdy[2]), 32'd1);
    cyc();
    drain();

    // Ten fill/drain rounds across pointer wrap.
    for (int r = 0; r < 10; r++) begin
      for (int j = 0; j < 3; j++) begin
        drive(1'b1, 16'(16'h0200 + r * 16 + j), 1'b0);
        cyc();
      end
      drive(1'b0, '0, 1'b1);
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        chk("wrap.data", 32'(od[2]), 32'(16'h0200 + r * 16 + j));
        cyc();
      end
    end
    drain();

    // Flush mid-stream with a handshake in the same cycle.
    drive(1'b1, 16'h31, 1'b0); cyc();
    drive(1'b1, 16'h32, 1'b0); cyc();
    flush = 1'b1;
    drive(1'b1, 16'h77, 1'b0);
    @(negedge clk);
    chk("flush.pre_count", cnt[0], 32'd2);
    chk("flush.pre_in_rdy", 32'(rdy[0]), 32'd1);
    cyc();
    flush = 1'b0;
    drive(1'b1, 16'h5A, 1'b0);
    @(negedge clk);
    chk("flush.count", cnt[0], 32'd0);
    chk("flush.in_rdy", 32'(rdy[0]), 32'd0);
    chk("flush.vld", 32'(ovld[0]), 32'd0);
    cyc();
    @(negedge clk);
    chk("flush.resume_in_rdy", 32'(rdy[0]), 32'd1);
    cyc();
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("flush.new_count", cnt[0], 32'd1);
    chk("flush.new_data", 32'(od[0]), 32'h005A);
    cyc();
    drain();

    // Same sequence using reset instead of flush.
    drive(1'b1, 16'h31, 1'b0); cyc();
    drive(1'b1, 16'h32, 1'b0); cyc();
    rst = 1'b1;
    drive(1'b1, 16'h77, 1'b0);
    @(negedge clk);
    chk("rstm.pre_count", cnt[0], 32'd2);
    cyc();
    rst = 1'b0;
    drive(1'b1, 16'h5A, 1'b0);
    @(negedge clk);
    chk("rstm.count", cnt[0], 32'd0);
    chk("rstm.in_rdy", 32'(rdy[0]), 32'd1);
    chk("rstm.vld", 32'(ovld[0]), 32'd0);
    cyc();
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("rstm.new_count", cnt[0], 32'd1);
    chk("rstm.new_data", 32'(od[0]), 32'h005A);
    chk("rstm.new_vld", 32'(ovld[0]), 32'd1);
    cyc();
    drain();

    // Random traffic with occasional flushes, all instances model-checked.
    repeat (600) begin
      in_vld  = ($urandom_range(0, 1) == 1);
      in_data = 16'($urandom);
      out_rdy = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 15) == 0);
      cyc();
    end
    drain();

    summary();
    $finish;
  end

endmodule
